// File: rtl/fb_wr_arbiter.sv
// fb_wr_arbiter
//   Owns the single frame-buffer write path into ram_wr. Pixels come from two
//   drawing requesters (A: game fsm, B: overlay/score drawer) and from an
//   internal clear-screen engine. At most one pixel is written per clock.
//
//   Ports
//     clk50M, rst_n          system clock, asynchronous active-low reset
//     clr_start, clr_color   one-cycle request to fill the screen with clr_color
//     clr_busy               clear engine currently owns the write path
//     a_* / b_*              valid/ready pixel requesters (x 8b, y 9b, colour 3b)
//     x, y, color, write_en  registered write command to ram_wr
//     oob_err                one-cycle pulse for an accepted off-screen pixel
//
//   Requester handshakes complete combinationally (ready in the same cycle as
//   valid); the resulting write reaches ram_wr one clock later.
module fb_wr_arbiter #(
  parameter int WIDTH        = 240,
  parameter int HEIGHT       = 320,
  parameter int CLR_ON_RESET = 1
) (
  input  logic       clk50M,
  input  logic       rst_n,
  input  logic       clr_start,
  input  logic [2:0] clr_color,
  output logic       clr_busy,
  input  logic       a_valid,
  input  logic [7:0] a_x,
  input  logic [8:0] a_y,
  input  logic [2:0] a_color,
  output logic       a_ready,
  input  logic       b_valid,
  input  logic [7:0] b_x,
  input  logic [8:0] b_y,
  input  logic [2:0] b_color,
  output logic       b_ready,
  output logic [7:0] x,
  output logic [8:0] y,
  output logic [2:0] color,
  output logic       write_en,
  output logic       oob_err
);

  typedef enum logic {
    ST_ARB   = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  localparam state_t     RST_STATE = (CLR_ON_RESET != 0) ? ST_CLEAR : ST_ARB;
  localparam logic [7:0] X_LAST    = 8'(WIDTH - 1);
  localparam logic [8:0] Y_LAST    = 9'(HEIGHT - 1);
  localparam logic [31:0] W_U      = 32'(WIDTH);
  localparam logic [31:0] H_U      = 32'(HEIGHT);

  state_t     state, state_nxt;
  logic       rr_b;        // round-robin pointer: 0 favours A, 1 favours B
  logic [7:0] clr_x;
  logic [8:0] clr_y;
  logic [2:0] clr_col;
  logic       clr_last;

  logic       acc_a, acc_b, acc_any;
  logic [7:0] sel_x;
  logic [8:0] sel_y;
  logic [2:0] sel_color;
  logic       sel_in_rng;

  assign clr_last = (clr_x == X_LAST) && (clr_y == Y_LAST);

  // ---- FSM: state register ----
  always_ff @(posedge clk50M or negedge rst_n) begin
    if (!rst_n) state <= RST_STATE;
    else        state <= state_nxt;
  end

  // ---- FSM: next state ----
  always_comb begin
    state_nxt = state;
    case (state)
      ST_ARB:   if (clr_start) state_nxt = ST_CLEAR;
      ST_CLEAR: if (clr_last)  state_nxt = ST_ARB;
      default:  state_nxt = ST_ARB;
    endcase
  end

  // ---- FSM: outputs (grant decision) ----
  // A clr_start in ARB wins over both requesters in the same cycle.
  always_comb begin
    a_ready  = 1'b0;
    b_ready  = 1'b0;
    clr_busy = (state == ST_CLEAR);
    if (state == ST_ARB && !clr_start) begin
      if (a_valid && b_valid) begin
        a_ready = !rr_b;
        b_ready = rr_b;
      end else begin
        a_ready = a_valid;
        b_ready = b_valid;
      end
    end
  end

  assign acc_a   = a_valid && a_ready;
  assign acc_b   = b_valid && b_ready;
  assign acc_any = acc_a || acc_b;

  always_comb begin
    sel_x     = acc_b ? b_x     : a_x;
    sel_y     = acc_b ? b_y     : a_y;
    sel_color = acc_b ? b_color : a_color;
  end

  assign sel_in_rng = (32'(sel_x) < W_U) && (32'(sel_y) < H_U);

  // ---- write-port register stage ----
  // Coordinates and colour hold their last values when nothing is written;
  // only the strobes are pulsed.
  always_ff @(posedge clk50M or negedge rst_n) begin
    if (!rst_n) begin
      x        <= '0;
      y        <= '0;
      color    <= '0;
      write_en <= 1'b0;
      oob_err  <= 1'b0;
      rr_b     <= 1'b0;
      clr_x    <= '0;
      clr_y    <= '0;
      clr_col  <= '0;
    end else begin
      write_en <= 1'b0;
      oob_err  <= 1'b0;
      if (state == ST_CLEAR) begin
        x        <= clr_x;
        y        <= clr_y;
        color    <= clr_col;
        write_en <= 1'b1;
        // Raster scan, x inner; both counters return to 0 after the last
        // pixel so the next clear starts at the origin.
        if (clr_last) begin
          clr_x <= '0;
          clr_y <= '0;
        end else if (clr_x == X_LAST) begin
          clr_x <= '0;
          clr_y <= clr_y + 9'd1;
        end else begin
          clr_x <= clr_x + 8'd1;
        end
      end else if (clr_start) begin
        clr_col <= clr_color;
        clr_x   <= '0;
        clr_y   <= '0;
      end else if (acc_any) begin
        rr_b <= acc_a;
        if (sel_in_rng) begin
          x        <= sel_x;
          y        <= sel_y;
          color    <= sel_color;
          write_en <= 1'b1;
        end else begin
          oob_err  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_fb_wr_arbiter.sv
// Testbench for fb_wr_arbiter. The screen geometry is shrunk to 16x24 so a
// full clear pass is 384 strobes; coordinates used below are chosen so the
// hand-computed values still exercise in-range, last-column/row and
// off-screen cases.
module tb_fb_wr_arbiter;

  localparam int W    = 16;
  localparam int H    = 24;
  localparam int NPIX = W * H;

  logic       clk50M = 1'b0;
  logic       rst_n;
  logic       clr_start;
  logic [2:0] clr_color;
  logic       clr_busy;
  logic       a_valid, b_valid;
  logic [7:0] a_x, b_x;
  logic [8:0] a_y, b_y;
  logic [2:0] a_color, b_color;
  logic       a_ready, b_ready;
  logic [7:0] x;
  logic [8:0] y;
  logic [2:0] color;
  logic       write_en;
  logic       oob_err;

  int n_cmp = 0;
  int n_err = 0;

  fb_wr_arbiter #(.WIDTH(W), .HEIGHT(H), .CLR_ON_RESET(1)) dut (
    .clk50M   (clk50M),
    .rst_n    (rst_n),
    .clr_start(clr_start),
    .clr_color(clr_color),
    .clr_busy (clr_busy),
    .a_valid  (a_valid),
    .a_x      (a_x),
    .a_y      (a_y),
    .a_color  (a_color),
    .a_ready  (a_ready),
    .b_valid  (b_valid),
    .b_x      (b_x),
    .b_y      (b_y),
    .b_color  (b_color),
    .b_ready  (b_ready),
    .x        (x),
    .y        (y),
    .color    (color),
    .write_en (write_en),
    .oob_err  (oob_err)
  );

  always #5 clk50M = ~clk50M;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk50M);
    #1;
  endtask

  // Entered in a cycle where the clear engine owns the path (before the edge
  // that registers pixel 0). Checks n_strobes consecutive raster writes.
  task automatic run_clear(input string tag, input logic [2:0] col,
                           input int n_strobes, input int restart_at);
    int bad_wr = 0, bad_pos = 0, bad_col = 0, bad_busy = 0, bad_rdy = 0;
    for (int k = 0; k < n_strobes; k++) begin
      if (a_ready !== 1'b0 || b_ready !== 1'b0) bad_rdy++;
      if (k == restart_at) begin
        clr_start = 1'b1;
        clr_color = 3'b111;
      end else begin
        clr_start = 1'b0;
      end
      tick();
      if (write_en !== 1'b1) bad_wr++;
      if (x !== 8'(k % W) || y !== 9'(k / W)) bad_pos++;
      if (color !== col) bad_col++;
      if (clr_busy !== (k != NPIX - 1)) bad_busy++;
    end
    clr_start = 1'b0;
    chk_eq({tag, "_ready_held"}, bad_rdy, 0);
    chk_eq({tag, "_wr_strobe"}, bad_wr, 0);
    chk_eq({tag, "_raster_pos"}, bad_pos, 0);
    chk_eq({tag, "_color"}, bad_col, 0);
    chk_eq({tag, "_busy"}, bad_busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; clr_start = 1'b0; clr_color = 3'b000;
    a_valid = 1'b0; a_x = '0; a_y = '0; a_color = '0;
    b_valid = 1'b0; b_x = '0; b_y = '0; b_color = '0;

    // T1: reset values, then automatic clear with colour 000
    #12;
    chk_eq("rst_x", x, 0);
    chk_eq("rst_y", y, 0);
    chk_eq("rst_color", color, 0);
    chk_eq("rst_write_en", write_en, 0);
    chk_eq("rst_oob", oob_err, 0);
    chk_eq("rst_readies", {a_ready, b_ready}, 0);
    chk_eq("rst_busy", clr_busy, 1);
    #10 rst_n = 1'b1;                       // release at 22, away from edges
    run_clear("t1", 3'b000, NPIX, -1);
    chk_eq("t1_last_x", x, W - 1);
    chk_eq("t1_last_y", y, H - 1);
    tick();
    chk_eq("t1_post_we", write_en, 0);

    // T2: A alone, same-cycle ready, one-clock latency
    a_valid = 1'b1; a_x = 8'd10; a_y = 9'd20; a_color = 3'b100;
    #1;
    chk_eq("t2_ready", {a_ready, b_ready}, 2'b10);
    tick();
    a_valid = 1'b0;
    chk_eq("t2_xyc", {x, y, color}, {8'd10, 9'd20, 3'b100});
    chk_eq("t2_we", write_en, 1);
    tick();
    chk_eq("t2_idle_we", write_en, 0);
    chk_eq("t2_idle_hold", {x, y, color}, {8'd10, 9'd20, 3'b100});

    // B alone at the last in-range column/row (pointer then returns to A)
    b_valid = 1'b1; b_x = 8'd15; b_y = 9'd23; b_color = 3'b111;
    #1;
    chk_eq("edge_ready", {a_ready, b_ready}, 2'b01);
    tick();
    b_valid = 1'b0;
    chk_eq("edge_xyc", {x, y, color, write_en, oob_err}, {8'd15, 9'd23, 3'b111, 1'b1, 1'b0});

    // T3: both held six cycles, pointer at A -> A,B,A,B,A,B
    a_valid = 1'b1; a_x = 8'd1; a_y = 9'd2; a_color = 3'b001;
    b_valid = 1'b1; b_x = 8'd3; b_y = 9'd4; b_color = 3'b010;
    #1;
    for (int i = 0; i < 6; i++) begin
      chk_eq($sformatf("t3_ready%0d", i), {a_ready, b_ready}, (i % 2 == 0) ? 2'b10 : 2'b01);
      tick();
      if (i % 2 == 0)
        chk_eq($sformatf("t3_wr%0d", i), {x, y, color, write_en}, {8'd1, 9'd2, 3'b001, 1'b1});
      else
        chk_eq($sformatf("t3_wr%0d", i), {x, y, color, write_en}, {8'd3, 9'd4, 3'b010, 1'b1});
    end
    a_valid = 1'b0; b_valid = 1'b0;

    // T4: off-screen pixels are consumed but not written
    b_valid = 1'b1; b_x = 8'd240; b_y = 9'd5; b_color = 3'b011;
    #1;
    chk_eq("t4a_ready", {a_ready, b_ready}, 2'b01);
    tick();
    chk_eq("t4a_we_oob", {write_en, oob_err}, 2'b01);
    chk_eq("t4a_hold", {x, y, color}, {8'd3, 9'd4, 3'b010});
    b_x = 8'd0; b_y = 9'd320;
    #1;
    chk_eq("t4b_ready", b_ready, 1);
    tick();
    b_valid = 1'b0;
    chk_eq("t4b_we_oob", {write_en, oob_err}, 2'b01);
    a_valid = 1'b1; a_x = 8'd16; a_y = 9'd0; a_color = 3'b001;
    #1;
    chk_eq("t4c_ready", a_ready, 1);
    tick();
    a_valid = 1'b0;
    chk_eq("t4c_we_oob", {write_en, oob_err}, 2'b01);
    tick();
    chk_eq("t4_oob_pulse", oob_err, 0);

    // T5: clr_start while A waits; second clr_start mid-clear is ignored
    a_valid = 1'b1; a_x = 8'd5; a_y = 9'd6; a_color = 3'b001;
    clr_start = 1'b1; clr_color = 3'b010;
    #1;
    chk_eq("t5_start_ready", {a_ready, b_ready}, 2'b00);
    chk_eq("t5_start_busy", clr_busy, 0);
    tick();
    clr_start = 1'b0; clr_color = 3'b101;
    chk_eq("t5_busy", clr_busy, 1);
    chk_eq("t5_no_grant_we", write_en, 0);
    run_clear("t5", 3'b010, NPIX, 100);
    chk_eq("t5_first_arb_ready", a_ready, 1);
    tick();
    a_valid = 1'b0;
    chk_eq("t5_a_write", {x, y, color, write_en}, {8'd5, 9'd6, 3'b001, 1'b1});

    // T6: asynchronous reset in the middle of a clear
    clr_start = 1'b1; clr_color = 3'b011;
    tick();
    clr_start = 1'b0;
    run_clear("t6pre", 3'b011, 50, -1);
    #2 rst_n = 1'b0;
    #1;
    chk_eq("t6_async_out", {x, y, color, write_en, oob_err}, 0);
    chk_eq("t6_async_busy", clr_busy, 1);
    #2 rst_n = 1'b1;
    run_clear("t6", 3'b000, NPIX, -1);

    // Pointer is back at A after reset: contention grants A first
    a_valid = 1'b1; a_x = 8'd7; a_y = 9'd8; a_color = 3'b110;
    b_valid = 1'b1; b_x = 8'd9; b_y = 9'd10; b_color = 3'b001;
    #1;
    chk_eq("rr_rst_ready", {a_ready, b_ready}, 2'b10);
    tick();
    a_valid = 1'b0; b_valid = 1'b0;
    chk_eq("rr_rst_write", {x, y, color, write_en}, {8'd7, 9'd8, 3'b110, 1'b1});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
